// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file writeback path: widths and
// instruction field positions used by regfile_writeback and its FIFO.
package regfile_writeback_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned REG_AW   = 5;

  localparam int unsigned RD_LSB   = 7;
  localparam int unsigned RS1_LSB  = 15;
  localparam int unsigned RS2_LSB  = 20;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order writeback FIFO: circular storage, pointers, count and status.
// With WB_BYPASS_EN defined it also exposes every entry in age order.
module regfile_writeback_wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [REG_AW-1:0]        rd_i,
  input  logic [XLEN-1:0]          data_i,
  output logic [REG_AW-1:0]        head_rd_o,
  output logic [XLEN-1:0]          head_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0]             ent_valid_o,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_rd_o,
  output logic [DEPTH-1:0][XLEN-1:0]   ent_data_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_rd_o   = rd_mem[rptr_q];
  assign head_data_o = data_mem[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked by the top while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      rd_mem[wptr_q]   <= rd_i;
      data_mem[wptr_q] <= data_i;
    end
  end

`ifdef WB_BYPASS_EN
  // Index 0 is the oldest pending entry, index count-1 the youngest.
  always_comb begin
    ent_valid_o = '0;
    ent_rd_o    = '0;
    ent_data_o  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid_o[i] = (CW'(i) < cnt_q);
      ent_rd_o[i]    = rd_mem[rptr_q + PW'(i)];
      ent_data_o[i]  = data_mem[rptr_q + PW'(i)];
    end
  end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Writeback buffer feeding the register-file write port, with x0 filtering.
// Define WB_BYPASS_EN to forward pending values onto ReadData1/ReadData2.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   drain_en,
  output logic                   RegWrite,
  output logic [REG_AW-1:0]      WriteRegister,
  output logic [XLEN-1:0]        WriteData,
  input  logic [31:0]            instruction,
  input  logic [XLEN-1:0]        ReadData1_in,
  input  logic [XLEN-1:0]        ReadData2_in,
  output logic [XLEN-1:0]        ReadData1,
  output logic [XLEN-1:0]        ReadData2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  logic              push, pop;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
  logic [DEPTH-1:0][XLEN-1:0]   ent_data;
`endif

  assign wb_ready = !full;
  // Writes to x0 complete the handshake but are dropped here.
  assign push     = wb_valid && wb_ready && (wb_rd != '0);
  assign pop      = RegWrite;

  assign RegWrite      = !empty && drain_en;
  assign WriteRegister = empty ? '0 : head_rd;
  assign WriteData     = empty ? '0 : head_data;

  regfile_writeback_wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_wb_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (push),
    .pop_i       (pop),
    .rd_i        (wb_rd),
    .data_i      (wb_data),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full)
`ifdef WB_BYPASS_EN
    ,
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd),
    .ent_data_o  (ent_data)
`endif
  );

`ifdef WB_BYPASS_EN
  reg_addr_t rs1, rs2;
  logic      unused_instr;

  assign rs1          = instruction[RS1_LSB +: REG_AW];
  assign rs2          = instruction[RS2_LSB +: REG_AW];
  assign unused_instr = ^{instruction[31:25], instruction[14:0]};

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    ReadData1 = ReadData1_in;
    ReadData2 = ReadData2_in;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (rs1 != '0) && (ent_rd[i] == rs1)) ReadData1 = ent_data[i];
      if (ent_valid[i] && (rs2 != '0) && (ent_rd[i] == rs2)) ReadData2 = ent_data[i];
    end
  end
`else
  logic unused_instr;

  assign unused_instr = ^instruction;
  assign ReadData1    = ReadData1_in;
  assign ReadData2    = ReadData2_in;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback against a queue-based model.
// Forwarding expectations follow WB_BYPASS_EN when it is defined.
module tb_regfile_writeback;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wb_valid = 1'b0;
  logic            wb_ready;
  logic [4:0]      wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            drain_en = 1'b0;
  logic            RegWrite;
  logic [4:0]      WriteRegister;
  logic [XLEN-1:0] WriteData;
  logic [31:0]     instruction = '0;
  logic [XLEN-1:0] ReadData1_in = '0;
  logic [XLEN-1:0] ReadData2_in = '0;
  logic [XLEN-1:0] ReadData1, ReadData2;
  logic [2:0]      count;
  logic            empty, full;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t model_q[$];
  ent_t exp_q[$];
  ent_t obs_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .drain_en      (drain_en),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .instruction   (instruction),
    .ReadData1_in  (ReadData1_in),
    .ReadData2_in  (ReadData2_in),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  // Record every register-file write the DUT commits at the next rising edge.
  always @(negedge clk) begin
    if (reset && RegWrite) obs_q.push_back({WriteRegister, WriteData});
  end

  // One clock: drive inputs, advance the model with the accept/drain rules.
  task automatic step(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d,
                      input logic dr);
    int unsigned sz;
    wb_valid = v; wb_rd = rd; wb_data = d; drain_en = dr;
    @(posedge clk);
    sz = model_q.size();
    if (dr && sz > 0) exp_q.push_back(model_q.pop_front());
    if (v && sz < DEPTH && rd != 5'd0) model_q.push_back({rd, d});
    #1;
  endtask

  function automatic logic [XLEN-1:0] fwd_exp(input logic [4:0] rs, input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] r;
    r = raw;
`ifdef WB_BYPASS_EN
    if (rs != 5'd0)
      for (int i = 0; i < model_q.size(); i++)
        if (model_q[i].rd == rs) r = model_q[i].data;
`endif
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; drain_en = 1'b1; wb_valid = 1'b0;
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wb_ready); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (WriteRegister !== 5'd0 || WriteData !== '0) begin
      errors++; $display("FAIL reset_wdata got %0d/%h want 0/0", WriteRegister, WriteData); end
    @(posedge clk); #1;
    reset = 1'b1; drain_en = 1'b0;
    model_q.delete(); exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single();
    step(1'b1, 5'd5, 64'h1234, 1'b1);
    wb_valid = 1'b0; #1;
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 64'h1234) begin
      errors++; $display("FAIL single_write got %b/%0d/%h want 1/5/1234", RegWrite, WriteRegister, WriteData); end
    step(1'b0, 5'd0, '0, 1'b1);
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL single_count got %0d/%b want 0/1", count, empty); end
    checks++; if (obs_q.size() != exp_q.size() || (exp_q.size() > 0 && obs_q[0] !== exp_q[0])) begin
      errors++; $display("FAIL single_log got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) step(1'b1, 5'(k), {$urandom, $urandom}, 1'b0);
    checks++; if (full !== 1'b1 || wb_ready !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL full_status got %b/%b/%0d want 1/0/4", full, wb_ready, count); end
    step(1'b1, 5'd9, 64'hDEAD, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_fifth got %0d want 4", count); end
    wb_valid = 1'b0; drain_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(k)) begin
        errors++; $display("FAIL full_drain%0d got %b/%0d want 1/%0d", k, RegWrite, WriteRegister, k); end
      step(1'b0, 5'd0, '0, 1'b1);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b want 1", empty); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_log_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_log%0d got %0d/%h want %0d/%h", i, obs_q[i].rd, obs_q[i].data, exp_q[i].rd, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_x0();
    step(1'b1, 5'd0, 64'hFFFF, 1'b1);
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL x0_count got %0d/%b want 0/1", count, empty); end
    wb_valid = 1'b0; #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_regwrite got %b want 0", RegWrite); end
    step(1'b0, 5'd0, '0, 1'b1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL x0_log got %0d writes want 0", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stream();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 5'((k % 31) + 1), {$urandom, $urandom}, 1'b1);
      checks++; if (count > 3'd1 || count !== 3'(model_q.size())) begin
        errors++; $display("FAIL stream_count%0d got %0d want %0d", k, count, model_q.size()); end
    end
    step(1'b0, 5'd0, '0, 1'b1);
    checks++; if (obs_q.size() != 20 || exp_q.size() != 20) begin
      errors++; $display("FAIL stream_log_len got %0d want 20 (model %0d)", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stream_log%0d got %0d/%h want %0d/%h", i, obs_q[i].rd, obs_q[i].data, exp_q[i].rd, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_forward();
    logic [XLEN-1:0] e1, e2;
    step(1'b1, 5'd7, 64'hAAAA_0000_0000_000A, 1'b0);
    step(1'b1, 5'd7, 64'hBBBB_0000_0000_000B, 1'b0);
    wb_valid = 1'b0;
    instruction = {7'd0, 5'd8, 5'd7, 15'd0};
    ReadData1_in = '0; ReadData2_in = {$urandom, $urandom};
    #1;
`ifdef WB_BYPASS_EN
    e1 = 64'hBBBB_0000_0000_000B;
`else
    e1 = '0;
`endif
    e2 = ReadData2_in;
    checks++; if (ReadData1 !== e1) begin errors++; $display("FAIL fwd_rs1 got %h want %h", ReadData1, e1); end
    checks++; if (ReadData2 !== e2) begin errors++; $display("FAIL fwd_rs2 got %h want %h", ReadData2, e2); end
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 5'($urandom_range(0, 6)), {$urandom, $urandom}, $urandom_range(0, 2) == 0);
      wb_valid = 1'b0; drain_en = 1'b0;
      instruction = {$urandom} & 32'hFE0F_FFFF;
      instruction[19:15] = 5'($urandom_range(0, 6));
      instruction[24:20] = 5'($urandom_range(0, 6));
      ReadData1_in = {$urandom, $urandom}; ReadData2_in = {$urandom, $urandom};
      #1;
      e1 = fwd_exp(instruction[19:15], ReadData1_in);
      e2 = fwd_exp(instruction[24:20], ReadData2_in);
      checks++; if (ReadData1 !== e1 || ReadData2 !== e2) begin
        errors++; $display("FAIL fwd_rand%0d got %h/%h want %h/%h", k, ReadData1, ReadData2, e1, e2); end
    end
    for (int k = 0; k < 8; k++) step(1'b0, 5'd0, '0, 1'b1);
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fwd_log_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fwd_log%0d got %0d/%h want %0d/%h", i, obs_q[i].rd, obs_q[i].data, exp_q[i].rd, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic v, dr;
    logic [4:0] rd;
    logic [XLEN-1:0] d;
    for (int k = 0; k < 300; k++) begin
      v = ($urandom_range(0, 3) != 0); rd = 5'($urandom_range(0, 7));
      d = {$urandom, $urandom}; dr = ($urandom_range(0, 2) != 0);
      wb_valid = v; wb_rd = rd; wb_data = d; drain_en = dr;
      #1;
      checks++; if (wb_ready !== (model_q.size() < DEPTH) || count !== 3'(model_q.size())
                    || RegWrite !== (dr && model_q.size() > 0)) begin
        errors++; $display("FAIL rand_status%0d got rdy=%b cnt=%0d rw=%b want cnt=%0d", k, wb_ready, count, RegWrite, model_q.size()); end
      step(v, rd, d, dr);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 5'd0, '0, 1'b1);
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_log_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_log%0d got %0d/%h want %0d/%h", i, obs_q[i].rd, obs_q[i].data, exp_q[i].rd, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 3; k++) step(1'b1, 5'(k + 10), {$urandom, $urandom}, 1'b0);
    wb_valid = 1'b0; drain_en = 1'b1; reset = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || RegWrite !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL rst_mid got empty=%b rw=%b cnt=%0d want 1/0/0", empty, RegWrite, count); end
    checks++; if (WriteRegister !== 5'd0 || WriteData !== '0) begin
      errors++; $display("FAIL rst_mid_wdata got %0d/%h want 0/0", WriteRegister, WriteData); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_q.delete(); exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 3; k++) step(1'b0, 5'd0, '0, 1'b1);
    checks++; if (obs_q.size() != 0 || count !== 3'd0) begin
      errors++; $display("FAIL rst_stale got %0d writes cnt=%0d want 0/0", obs_q.size(), count); end
    step(1'b1, 5'd21, 64'h5555, 1'b1);
    step(1'b0, 5'd0, '0, 1'b1);
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL rst_after got %0d writes want 1", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_x0();
    test_stream();
    test_forward();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
